// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field layout, direction encoding and the
// deterministic XY routing function used by every router stage.
package noc_pkg;

    localparam int PACK_WIDTH_DEF = 51;
    localparam int COORD_W_DEF    = 4;

    localparam int DST_X_MSB = PACK_WIDTH_DEF - 1;
    localparam int DST_X_LSB = DST_X_MSB - COORD_W_DEF + 1;
    localparam int DST_Y_MSB = DST_X_LSB - 1;
    localparam int DST_Y_LSB = DST_Y_MSB - COORD_W_DEF + 1;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    localparam int NUM_DIRS = 5;

    // X is resolved fully before Y, which keeps the mesh deadlock-free.
    function automatic logic [NUM_DIRS-1:0] xy_route(
        input logic [COORD_W_DEF-1:0] dst_x,
        input logic [COORD_W_DEF-1:0] dst_y,
        input logic [COORD_W_DEF-1:0] my_x,
        input logic [COORD_W_DEF-1:0] my_y
    );
        logic [NUM_DIRS-1:0] oh;
        oh = '0;
        if (dst_x > my_x)
            oh[DIR_RIGHT] = 1'b1;
        else if (dst_x < my_x)
            oh[DIR_LEFT] = 1'b1;
        else if (dst_y > my_y)
            oh[DIR_UP] = 1'b1;
        else if (dst_y < my_y)
            oh[DIR_DOWN] = 1'b1;
        else
            oh[DIR_LOCAL] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/xy_route_decode.sv
// Combinational destination decode: one-hot XY route plus mesh range check.
module xy_route_decode
    import noc_pkg::*;
#(
    parameter int COORD_W = noc_pkg::COORD_W_DEF,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4
) (
    input  logic [COORD_W-1:0]  dst_x,
    input  logic [COORD_W-1:0]  dst_y,
    output logic [NUM_DIRS-1:0] route,
    output logic                illegal
);

    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);
    // One extra bit so a mesh spanning the full coordinate range still compares correctly.
    localparam logic [COORD_W:0]   MESH_X_C = (COORD_W+1)'(MESH_X);
    localparam logic [COORD_W:0]   MESH_Y_C = (COORD_W+1)'(MESH_Y);

    always_comb begin
        route   = xy_route(dst_x, dst_y, MY_X_C, MY_Y_C);
        illegal = ({1'b0, dst_x} >= MESH_X_C) || ({1'b0, dst_y} >= MESH_Y_C);
    end

endmodule

// File: rtl/xy_route_stage.sv
// Single-entry route-compute/switch stage behind the 5-input arbiter.
// Optional per-direction and drop statistics: define XY_ROUTE_STATS_EN.
module xy_route_stage
    import noc_pkg::*;
#(
    parameter int PACK_WIDTH = noc_pkg::PACK_WIDTH_DEF,
    parameter int COORD_W    = noc_pkg::COORD_W_DEF,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PACK_WIDTH-1:0] in_data,
    output logic [4:0]            out_valid,
    input  logic [4:0]            out_ready,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic                  drop_err
`ifdef XY_ROUTE_STATS_EN
    ,
    output logic [5*16-1:0]       pkt_count,
    output logic [15:0]           drop_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state;
    logic [NUM_DIRS-1:0] route;
    logic                illegal;
    logic                in_fire;
    logic                out_fire;

    xy_route_decode #(
        .COORD_W (COORD_W),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y),
        .MESH_X  (MESH_X),
        .MESH_Y  (MESH_Y)
    ) u_decode (
        .dst_x   (in_data[PACK_WIDTH-1 -: COORD_W]),
        .dst_y   (in_data[PACK_WIDTH-1-COORD_W -: COORD_W]),
        .route   (route),
        .illegal (illegal)
    );

    // out_valid is zero when EMPTY, so the masked OR is the output transfer.
    assign out_fire = |(out_valid & out_ready);
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!rst)
            in_ready = (state == EMPTY) ? 1'b1 : out_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            drop_err  <= 1'b0;
        end else begin
            drop_err <= in_fire & illegal;
            if (in_fire && !illegal) begin
                state     <= FULL;
                out_valid <= route;
                out_data  <= in_data;
            end else if (out_fire) begin
                state     <= EMPTY;
                out_valid <= '0;
            end
        end
    end

`ifdef XY_ROUTE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIRS; i++) begin
                if (out_valid[i] && out_ready[i] && (pkt_count[i*16 +: 16] != 16'hFFFF))
                    pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
            end
            if (in_fire && illegal && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/xy_route_stage.md
Name: xy_route_stage

Overview:
- Clocked route-compute and switch stage sitting directly downstream of the router's 5-input arbiter.
- Consumes one 51-bit packet at a time from the arbiter output.
- Decodes the destination coordinates, picks one of five output directions by deterministic XY routing, and holds the packet until that direction's consumer accepts it.
- One per router node in the SNN mesh NoC.

Parameters:
- PACK_WIDTH, 51, packet width in bits.
- COORD_W, 4, width of each coordinate field.
- MY_X, 0, this node's X coordinate.
- MY_Y, 0, this node's Y coordinate.
- MESH_X, 4, mesh columns; valid X range is 0..MESH_X-1.
- MESH_Y, 4, mesh rows; valid Y range is 0..MESH_Y-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  arbiter output packet valid.
- in_ready  out  1  stage can accept a packet.
- in_data  in  PACK_WIDTH  packet: [50:47] dst_x, [46:43] dst_y, [42:0] opaque payload.
- out_valid  out  5  one-hot; bit order 0 up, 1 down, 2 left, 3 right, 4 local.
- out_ready  in  5  per-direction accept, same bit order.
- out_data  out  PACK_WIDTH  held packet, shared by all directions, forwarded unmodified.
- drop_err  out  1  one-cycle pulse when an out-of-range packet is discarded.

Behaviour:
- Transfers: input transfer when in_valid & in_ready at a rising edge; output transfer when (out_valid & out_ready) != 0.
- Reset (rst=1 at an edge):
  - State goes to EMPTY; out_valid=0, drop_err=0, out_data=0.
  - Any held packet is discarded, even mid-stall; in_ready=0 while rst is high.
- State EMPTY:
  - in_ready=1.
  - On input transfer, compute route combinationally, register packet and one-hot route, go to FULL.
- Route compute, in priority order:
  - dst_x>MY_X → right; dst_x<MY_X → left.
  - Else dst_y>MY_Y → up; dst_y<MY_Y → down.
  - Else → local.
  - Comparisons are unsigned, COORD_W wide.
- Out-of-range destination (dst_x>=MESH_X or dst_y>=MESH_Y):
  - Packet is accepted and not stored; state is unchanged.
  - drop_err=1 on the following cycle for exactly one cycle.
- State FULL:
  - out_valid = registered one-hot route; out_data stable until the transfer completes.
  - Ready bits of non-selected directions are ignored.
- Transfer while FULL:
  - If in_valid is also presented, the new packet is accepted the same cycle (in_ready = selected out_ready while FULL) and FULL is retained with the new packet/route. This gives throughput of 1 packet/cycle.
  - Otherwise go to EMPTY.
- Latency: packet accepted at edge N is visible on out_valid/out_data after edge N, i.e. 1 cycle.
- Stall: FULL with selected out_ready=0 holds indefinitely with no reordering; in_ready=0.
- Simultaneous output transfer and out-of-range input: held packet leaves, state goes EMPTY, drop_err pulses.
- out_valid is never multi-hot. out_valid=0 in EMPTY.

Optional Feature:
- Macro: XY_ROUTE_STATS_EN.
- When defined:
  - Adds output port pkt_count of 5×16 bits (packed, direction-ordered) and output port drop_count of 16 bits.
  - Each counter increments on its direction's output transfer or on a drop, respectively.
  - Counters saturate at 16'hFFFF and clear on rst.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `noc_pkg`:
  - PACK_WIDTH and COORD_W defaults.
  - Field bit-position constants DST_X_MSB/LSB and DST_Y_MSB/LSB.
  - Direction enum dir_e {DIR_UP=0, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_LOCAL}.
  - Function xy_route(dst_x, dst_y, my_x, my_y) returning a 5-bit one-hot.
- One sub-module, `xy_route_decode`: combinational coordinate compare plus range check, producing the one-hot route and an illegal flag. The parent holds the state register and handshake.

Test Plan:
- MY_X=1, MY_Y=1, 4×4 mesh: send dst(3,0) with all out_ready=1 → out_valid=5'b01000 (right) one cycle later, out_data identical to input.
- Same config:
  - dst(1,3) → 5'b00001 (up); dst(1,0) → 5'b00010 (down); dst(0,2) → 5'b00100 (left); dst(1,1) → 5'b10000 (local).
- Back-to-back: 4 packets on consecutive cycles with out_ready=5'b11111 → 4 output transfers on consecutive cycles, in order, in_ready stays 1.
- Stall: dst(2,1), out_ready=5'b10111 for 5 cycles (right held low) → out_valid=5'b01000 held, in_ready=0, out_data stable; raise bit 3 → transfer, state EMPTY.
- Out-of-range: dst(5,0) → no out_valid, drop_err high exactly one cycle, in_ready stays 1; with XY_ROUTE_STATS_EN, drop_count=1.
- Reset while FULL and stalled: assert rst one cycle → out_valid=0 next cycle, packet never delivered, counters 0 (if enabled).
